// File: rtl/conway_pkg.sv
// Shared types and default dimensions for the Game of Life board scanner.
package conway_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int CONWAY_ROWS        = 8;
  localparam int CONWAY_COLS        = 8;
  localparam int CONWAY_FRAME_CNT_W = 16;

endpackage

// File: rtl/conway_row_popcount.sv
// Combinational binary adder tree counting live cells in one board row.
// Built only when CONWAY_SCANNER_POPCOUNT_EN is defined.
`ifdef CONWAY_SCANNER_POPCOUNT_EN
module conway_row_popcount #(
  parameter  int COLS = 8,
  localparam int PW   = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0] bits,
  output logic [PW-1:0]   pop
);

  generate
    if (COLS == 1) begin : g_leaf
      assign pop = bits;
    end else begin : g_node
      // Split the row in two halves and add their counts.
      localparam int LO = COLS / 2;
      localparam int HI = COLS - LO;
      localparam int LW = $clog2(LO + 1);
      localparam int HW = $clog2(HI + 1);

      logic [LW-1:0] lo_pop_s;
      logic [HW-1:0] hi_pop_s;

      conway_row_popcount #(.COLS(LO)) u_lo (
        .bits (bits[LO-1:0]),
        .pop  (lo_pop_s)
      );

      conway_row_popcount #(.COLS(HI)) u_hi (
        .bits (bits[COLS-1:LO]),
        .pop  (hi_pop_s)
      );

      assign pop = PW'(lo_pop_s) + PW'(hi_pop_s);
    end
  endgenerate

endmodule
`endif

// File: rtl/conway_board_scanner.sv
// Snapshots the live Game of Life board on request and streams it one row per
// valid/ready transfer. Optional row/frame popcount: CONWAY_SCANNER_POPCOUNT_EN.
module conway_board_scanner
  import conway_pkg::*;
#(
  parameter int ROWS = CONWAY_ROWS,
  parameter int COLS = CONWAY_COLS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            snap,
  input  logic [ROWS*COLS-1:0]            board_q,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [COLS-1:0]                 row_data,
  output logic [$clog2(ROWS)-1:0]         row_idx,
  output logic                            row_last,
  output logic                            busy,
  output logic                            frame_done,
  output logic [CONWAY_FRAME_CNT_W-1:0]   frame_count,
  output logic                            overrun,
  output logic [$clog2(COLS+1)-1:0]       row_pop,
  output logic [$clog2(ROWS*COLS+1)-1:0]  pop_total
);

  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(COLS + 1);
  localparam int TW = $clog2(ROWS * COLS + 1);
  localparam int FW = CONWAY_FRAME_CNT_W;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scan_state_t               state_r;
  scan_state_t               state_s;
  logic [ROWS-1:0][COLS-1:0] snap_r;
  logic [RW-1:0]             idx_r;
  logic [FW-1:0]             frame_count_r;
  logic                      overrun_r;
  logic                      accept_s;
  logic                      xfer_s;
  logic                      last_s;

  assign row_valid   = (state_r == SEND);
  assign last_s      = (idx_r == LAST_ROW);
  assign xfer_s      = row_valid & row_ready;
  assign row_data    = snap_r[idx_r];
  assign row_idx     = idx_r;
  assign row_last    = row_valid & last_s;
  assign busy        = (state_r != IDLE);
  assign frame_done  = (state_r == DONE);
  assign frame_count = frame_count_r;
  assign overrun     = overrun_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a snap is only accepted from IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (snap) begin
          state_s  = SEND;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && last_s) begin
          state_s = DONE;
        end else begin
          state_s = SEND;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Snapshot, row pointer, frame counter and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r        <= {(ROWS*COLS){1'b0}};
      idx_r         <= {RW{1'b0}};
      frame_count_r <= {FW{1'b0}};
      overrun_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        snap_r <= board_q;
        idx_r  <= {RW{1'b0}};
      end else if (xfer_s && !last_s) begin
        idx_r  <= idx_r + RW'(1);
      end
      if (state_r == DONE) begin
        frame_count_r <= frame_count_r + FW'(1);
      end
      if (snap && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

`ifdef CONWAY_SCANNER_POPCOUNT_EN
  logic [PW-1:0] pop_s;
  logic [TW-1:0] acc_r;
  logic [TW-1:0] total_r;

  conway_row_popcount #(.COLS(COLS)) u_pop (
    .bits (row_data),
    .pop  (pop_s)
  );

  // Accumulate live cells per transferred row; publish at the end of DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= {TW{1'b0}};
      total_r <= {TW{1'b0}};
    end else begin
      if (accept_s) begin
        acc_r <= {TW{1'b0}};
      end else if (xfer_s) begin
        acc_r <= acc_r + TW'(pop_s);
      end
      if (state_r == DONE) begin
        total_r <= acc_r;
      end
    end
  end

  assign row_pop   = pop_s;
  assign pop_total = total_r;
`else
  assign row_pop   = {PW{1'b0}};
  assign pop_total = {TW{1'b0}};
`endif

endmodule

// File: tb/tb_conway_board_scanner.sv
// Directed self-checking bench for conway_board_scanner (8x8 board).
module tb_conway_board_scanner;

`ifdef CONWAY_SCANNER_POPCOUNT_EN
  localparam bit POP_EN = 1'b1;
`else
  localparam bit POP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snap = 1'b0;
  logic [63:0] board_q = 64'd0;
  logic        row_valid;
  logic        row_ready = 1'b0;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_last;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overrun;
  logic [3:0]  row_pop;
  logic [6:0]  pop_total;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_fc = 16'd0;

  conway_board_scanner #(.ROWS(8), .COLS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .snap        (snap),
    .board_q     (board_q),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_last    (row_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overrun     (overrun),
    .row_pop     (row_pop),
    .pop_total   (pop_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, row_valid,   0);
    chk({tag, "_data"},  row_data,    0);
    chk({tag, "_idx"},   row_idx,     0);
    chk({tag, "_last"},  row_last,    0);
    chk({tag, "_busy"},  busy,        0);
    chk({tag, "_done"},  frame_done,  0);
    chk({tag, "_fc"},    frame_count, 0);
    chk({tag, "_ovr"},   overrun,     0);
    chk({tag, "_rpop"},  row_pop,     0);
    chk({tag, "_ptot"},  pop_total,   0);
  endtask

  // Full-speed frame; optionally raise snap while row snap_row is presented.
  task automatic run_frame(input string tag, input logic [63:0] b, input int snap_row);
    logic [7:0] rowv;
    board_q   = b;
    row_ready = 1'b1;
    snap      = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rowv = b[r*8 +: 8];
      chk({tag, "_valid"}, row_valid, 1);
      chk({tag, "_idx"},   row_idx,   r);
      chk({tag, "_data"},  row_data,  rowv);
      chk({tag, "_last"},  row_last,  (r == 7) ? 1 : 0);
      chk({tag, "_rpop"},  row_pop,   POP_EN ? $countones(rowv) : 0);
      snap = (r == snap_row);
      @(negedge clk);
    end
    snap = 1'b0;
    chk({tag, "_done"},  frame_done, 1);
    chk({tag, "_busyd"}, busy,       1);
    chk({tag, "_vdone"}, row_valid,  0);
    @(negedge clk);
    exp_fc = exp_fc + 16'd1;
    chk({tag, "_done1"}, frame_done,  0);
    chk({tag, "_busyi"}, busy,        0);
    chk({tag, "_fc"},    frame_count, exp_fc);
    chk({tag, "_ptot"},  pop_total,   POP_EN ? $countones(b) : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat;
    logic [63:0] snapv;
    logic [7:0]  held;
    int          k;
    int          exp_idx;
    bit          stalled;

    // Reset state.
    @(negedge clk);
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    // Basic frame: one bit per row.
    for (int r = 0; r < 8; r++) pat[r*8 +: 8] = 8'(1 << r);
    run_frame("basic", pat, -1);

    // Full board.
    run_frame("full", {64{1'b1}}, -1);

    // Backpressure with board changing mid-frame.
    for (int r = 0; r < 8; r++) pat[r*8 +: 8] = 8'(r * 37 + 5);
    snapv     = pat;
    board_q   = pat;
    row_ready = 1'b0;
    snap      = 1'b1;
    @(negedge clk);
    snap    = 1'b0;
    k       = 0;
    exp_idx = 0;
    stalled = 1'b0;
    held    = 8'd0;
    while (row_valid && k < 40) begin
      row_ready = k[0];
      chk("bp_idx",  row_idx,  exp_idx);
      chk("bp_data", row_data, snapv[exp_idx*8 +: 8]);
      if (stalled) chk("bp_hold", row_data, held);
      if (k == 2) board_q = {64{1'b1}};
      held    = row_data;
      stalled = !row_ready;
      @(negedge clk);
      if (row_ready) exp_idx++;
      k++;
    end
    chk("bp_cycles", k, 16);
    chk("bp_done", frame_done, 1);
    @(negedge clk);
    exp_fc = exp_fc + 16'd1;
    chk("bp_fc", frame_count, exp_fc);
    chk("bp_ptot", pop_total, POP_EN ? $countones(snapv) : 0);
    chk("bp_ovr0", overrun, 0);

    // Overrun: snap while row 3 is on the bus.
    pat = 64'h0123_4567_89AB_CDEF;
    run_frame("ovr", pat, 3);
    chk("ovr_flag", overrun, 1);
    run_frame("ovr2", 64'hF0F0_0F0F_AA55_33CC, -1);
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of a frame at row 5.
    board_q   = 64'hDEAD_BEEF_CAFE_F00D;
    row_ready = 1'b1;
    snap      = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("mid_idx", row_idx, 5);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_nodone", frame_done, 0);
    end
    rst    = 1'b0;
    exp_fc = 16'd0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    run_frame("fresh", 64'h8001_4002_2004_1008, -1);

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_count_r = 16'hFFFF;
    #1;
    release dut.frame_count_r;
    exp_fc = 16'hFFFF;
    @(negedge clk);
    chk("wrap_pre", frame_count, 16'hFFFF);
    run_frame("wrap", 64'h0000_0000_0000_0001, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
